// File: rtl/inst_line_buffer.sv
// Instruction line buffer: fetches one 64-byte line at a time from the fill
// engine and hands instructions to decode one per handshake. Redirects flush
// the buffer; a request already accepted by the fill engine is drained.
module inst_line_buffer #(
  parameter int LINE_WIDTH = 512,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           entry,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_pc,
  output logic                  line_req_valid,
  output logic [63:0]           line_req_addr,
  input  logic                  line_req_ready,
  input  logic                  line_resp_valid,
  input  logic [LINE_WIDTH-1:0] line_resp_data,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [63:0]           inst_pc,
  input  logic                  inst_ready
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [63:0]           pc, pc_nxt;
  logic [LINE_WIDTH-1:0] line_buf;
  logic                  capture;
  logic [63:0]           redir_pc;
  logic [INST_WIDTH-1:0] word;

  assign redir_pc = redirect_pc & ~64'd3;

  // Word select from the buffered line; pc is always word aligned.
  always_comb begin
    word = line_buf[int'(pc[5:2])*INST_WIDTH +: INST_WIDTH];
  end

  // Outputs are gated by reset so nothing is presented while reset is high.
  always_comb begin
    line_req_valid = (state == S_REQ) & ~reset;
    line_req_addr  = {pc[63:6], 6'b0};
    inst_valid     = (state == S_DELIVER) & ~reset;
    inst           = inst_valid ? word : '0;
    inst_pc        = inst_valid ? pc : '0;
  end

  // Next-state / pc update; redirect wins over every other event.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          // An accepted request still returns a line that must be dropped.
          state_nxt = line_req_ready ? S_DRAIN : S_REQ;
        end else if (line_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          // A coincident response is simply dropped; nothing left to drain.
          state_nxt = line_resp_valid ? S_REQ : S_DRAIN;
        end else if (line_resp_valid) begin
          capture   = 1'b1;
          state_nxt = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = S_REQ;
        end else if (inst_ready) begin
          pc_nxt = pc + 64'd4;
          if (pc[5:2] == 4'hF) state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) pc_nxt = redir_pc;
        // Leave once the stale line has arrived, even alongside a redirect,
        // since no further response would ever come.
        if (line_resp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // State, pc and line buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= entry & ~64'd3;
      line_buf <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) line_buf <= line_resp_data;
    end
  end

endmodule
